// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the bit-serial adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_addsub_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of W-bit chunks making up an N-bit operand.
    function automatic int cc_of(input int n, input int w);
        return n / w;
    endfunction

    // Chunk counter width; a single chunk still needs one counter bit.
    function automatic int cnt_width(input int n, input int w);
        int cc;
        cc = n / w;
        return (cc <= 1) ? 1 : $clog2(cc);
    endfunction

endpackage

// File: rtl/serial_addsub_slice.sv
// One W-bit ripple slice: a + (b ^ inv_b) + cin, with carry-out and signed overflow.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module serial_addsub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         inv_b,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         ovf
);

    logic [W-1:0] bx;
    logic [W-1:0] lo_sum;
    logic [1:0]   hi_sum;
    logic         c_msb;

    // Split the add below and at the MSB so the carry into the sign bit is visible.
    always_comb begin
        bx     = b ^ {W{inv_b}};
        lo_sum = {1'b0, a[W-2:0]} + {1'b0, bx[W-2:0]} + {{(W-1){1'b0}}, cin};
        c_msb  = lo_sum[W-1];
        hi_sum = {1'b0, a[W-1]} + {1'b0, bx[W-1]} + {1'b0, c_msb};
        s      = {hi_sum[0], lo_sum[W-2:0]};
        cout   = hi_sum[1];
        ovf    = c_msb ^ hi_sum[1];
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit add/sub over N/W LSB-first chunks, linked by one carry register.
// Latency: each accepted chunk's result appears one cycle later; done marks the last.
// Backpressure: none outward; in_valid=0 in RUN stalls with carry/count held.
module serial_addsub #(
    parameter int N = 16384,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         out_valid,
    output logic [W-1:0] c,
    output logic         done,
    output logic         cout,
    output logic         ovf
);

    import serial_addsub_pkg::*;

    localparam int CC = cc_of(N, W);
    localparam int CW = cnt_width(N, W);
    localparam logic [CW-1:0] LAST_CNT = CW'(CC - 1);

    if (N % W != 0) begin : g_bad_n
        $error("serial_addsub: N must be a multiple of W");
    end
    if (W < 2) begin : g_bad_w
        $error("serial_addsub: W must be at least 2");
    end

    state_t        state;
    state_t        state_nxt;
    logic          mode;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          last;
    logic [W-1:0]  sl_s;
    logic          sl_cout;
    logic          sl_ovf;

    assign busy   = (state == ST_RUN);
    assign accept = busy && in_valid;
    assign last   = (cnt == LAST_CNT);

    serial_addsub_slice #(.W(W)) u_slice (
        .a     (a),
        .b     (b),
        .cin   (carry),
        .inv_b (mode),
        .s     (sl_s),
        .cout  (sl_cout),
        .ovf   (sl_ovf)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: start launches a run; the final accepted chunk ends it.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start)            state_nxt = ST_RUN;
            ST_RUN:  if (in_valid && last) state_nxt = ST_IDLE;
            default:                       state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: mode/carry seeded at start (carry=1 gives the +1 of two's-complement
    // subtraction), advanced per accepted chunk, final flags captured on the last chunk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode      <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            c         <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= accept;
            done      <= accept && last;
            if (state == ST_IDLE && start) begin
                mode  <= sub;
                carry <= sub;
                cnt   <= '0;
            end
            if (accept) begin
                c     <= sl_s;
                carry <= sl_cout;
                cnt   <= cnt + CW'(1);
                if (last) begin
                    cout <= sl_cout;
                    ovf  <= sl_ovf;
                end
            end
        end
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor for the garbled-circuit netlist library. It adds or subtracts two N-bit operands presented LSB-first as W-bit chunks, one chunk per accepted cycle, over N/W chunks. A single carry register links the chunks. The block adds a start/valid/done handshake, input stalling, runtime add/sub mode, and final carry-out and signed-overflow flags, so it can be instantiated for any width and cycle-count trade-off.

## Interface
Parameters:
- N, default 16384: total operand width in bits; must be a multiple of W.
- W, default 4: chunk width in bits processed per accepted cycle; W ≥ 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begins an operation when the block is idle.
- sub  in  1  mode, sampled with start: 0 = a+b, 1 = a−b.
- in_valid  in  1  chunk a/b is present this cycle.
- a  in  W  operand A chunk, LSB-first order.
- b  in  W  operand B chunk, LSB-first order.
- busy  out  1  high in RUN.
- out_valid  out  1  c holds a result chunk.
- c  out  W  result chunk.
- done  out  1  one-cycle pulse marking the final result chunk.
- cout  out  1  final carry; for sub, 1 means no borrow; valid while done is high.
- ovf  out  1  two's-complement overflow of the full N-bit result; valid while done is high.

## Operation
- Chunk count: CC = N/W. Chunk counter cnt is $clog2(CC) bits wide, with a minimum of 1 bit.
- States:
  - IDLE: start=1 moves the block to RUN. On that move it sets mode←sub, carry←sub, cnt←0. Chunks are ignored in IDLE, including any chunk presented in the same cycle as start.
  - RUN: each cycle with in_valid=1 accepts one chunk. An accepted chunk computes {carry', s} = a + (b XOR {W{mode}}) + carry. It then registers c←s, sets carry←carry', and increments cnt.
  - Stall: a cycle with in_valid=0 in RUN leaves carry, cnt and mode unchanged.
  - Final chunk: the chunk accepted with cnt==CC−1 is the last. Its acceptance cycle returns the block to IDLE.
- Flags: ovf = carry into the MSB of the final chunk XOR carry out of it. cout = carry out of the final chunk.
- start is ignored in RUN, and sub is ignored outside the start cycle.
- Reset: rst=0 forces the IDLE state regardless of operation progress. It also clears carry, cnt, mode, c, out_valid, done, cout and ovf to 0. An interrupted operation is discarded; nothing is flushed.

## Timing
- Reset values: busy=0, out_valid=0, c=0, done=0, cout=0, ovf=0.
- Latency: one cycle. Chunk k accepted at edge t appears on c, with out_valid=1, after edge t.
- out_valid is high exactly for the one cycle following each accepted chunk. c holds its value when out_valid=0.
- The final chunk's output cycle has out_valid=1 and done=1, with cout and ovf valid. busy is already 0 in that cycle.
- Back-to-back operation: start is accepted in the done cycle, so the next operation's first chunk is accepted one cycle later. With no stalls, throughput is CC+1 cycles per operation.
- No ready output: the block is always ready in RUN. Upstream must not present chunks before busy=1.

## Structure
- serial_addsub_pkg holds:
  - the state enum (ST_IDLE, ST_RUN);
  - a function cc_of(N,W) returning N/W;
  - a function cnt_width(N,W) returning max(1, $clog2(N/W)).
- Sub-module serial_addsub_slice is purely combinational. Its inputs are a, b, cin and inv_b, each W-bit or 1-bit. Its outputs are s, cout and ovf. The top module holds the FSM, counter and registers.
- Elaboration asserts that N % W == 0 and that W ≥ 2.

## Test plan
Configuration N=16, W=4 unless noted.
- Add: 0x1234 + 0x0FFF, no stalls -> c = 3, 3, 2, 2 on consecutive cycles; done on the 4th chunk with cout=0, ovf=0.
- Subtract: 0x0000 − 0x0001 -> c = F, F, F, F; cout=0 (borrow), ovf=0.
- Signed overflow: 0x7FFF + 0x0001 -> c = 0, 0, 0, 8; ovf=1, cout=0.
- Stalls: repeat the Add case with in_valid low for 2 cycles between chunks 1 and 2, plus a chunk presented in the start cycle.
  - The start-cycle chunk is ignored.
  - Results are identical to the no-stall case, and done follows only the 4th accepted chunk.
- Reset mid-operation: rst=0 after 2 accepted chunks.
  - All outputs read 0 the next cycle.
  - A fresh 0x0001 + 0x0001 then yields c = 2, 0, 0, 0 with no carry leaking from the aborted operation.
- Default parameters (N=16384, W=4): random operands checked against a reference model; start pulsed during RUN.
  - The start pulse is ignored.
  - done asserts exactly once, on the 4096th chunk; then a back-to-back start in the done cycle is accepted.
